// File: rtl/shift_unit_pipe.sv
// rtl/shift_unit_pipe.sv - pipelined SLL/SRL/SRA/ROR shifter with carry and zero flags
module shift_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW:0]     in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    localparam logic [1:0]   OP_SLL = 2'b00;
    localparam logic [1:0]   OP_SRL = 2'b01;
    localparam logic [1:0]   OP_SRA = 2'b10;
    localparam logic [SHW:0] AMT_W  = (SHW+1)'(WIDTH);

    // Stage registers; the last stage is the output register and needs no op/amount.
    logic [SHW-1:0]   valid_q, valid_d;
    logic [SHW-1:0]   carry_q, carry_d;
    logic [WIDTH-1:0] data_q [SHW];
    logic [WIDTH-1:0] data_d [SHW];
    logic [1:0]       op_q   [SHW-1];
    logic [1:0]       op_d   [SHW-1];
    logic [SHW-1:0]   rem_q  [SHW-1];
    logic [SHW-1:0]   rem_d  [SHW-1];
    logic             zero_q, zero_d;

    logic             stall;
    logic             fire;
    logic             cap_sat;
    logic [SHW-1:0]   amt_lo;
    logic [SHW-1:0]   idx_dec;
    logic [SHW-1:0]   idx_neg;
    logic [SHW-1:0]   cap_amt;
    logic [WIDTH-1:0] cap_data;
    logic             cap_carry;

    logic [SHW-1:0]   src_valid;
    logic [SHW-1:0]   src_carry;
    logic [1:0]       src_op   [SHW];
    logic [SHW-1:0]   src_rem  [SHW];
    logic [WIDTH-1:0] src_data [SHW];

    assign stall     = valid_q[SHW-1] && !out_ready;
    assign in_ready  = !stall;
    assign fire      = in_valid && in_ready && !flush;
    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_carry = carry_q[SHW-1];
    assign out_zero  = zero_q;

    function automatic logic [WIDTH-1:0] shift_by(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] d,
                                                  input int sh);
        logic signed [WIDTH-1:0] sd;
        sd = d;
        case (op)
            OP_SLL:  shift_by = d << sh;
            OP_SRL:  shift_by = d >> sh;
            OP_SRA:  shift_by = sd >>> sh;
            default: shift_by = (d >> sh) | (d << (WIDTH - sh));
        endcase
    endfunction

    // Capture: normalise the amount (saturating non-rotates) and pick the carry bit up front.
    always_comb begin
        amt_lo    = in_amt[SHW-1:0];
        idx_dec   = amt_lo - SHW'(1);
        idx_neg   = SHW'(0) - amt_lo;
        cap_sat   = in_amt[SHW] && (in_op != 2'b11);
        cap_amt   = cap_sat ? '0 : amt_lo;
        cap_data  = in_data;
        if (cap_sat) begin
            cap_data = (in_op == OP_SRA) ? {WIDTH{in_data[WIDTH-1]}} : '0;
        end
        cap_carry = 1'b0;
        if (in_amt != '0) begin
            case (in_op)
                OP_SLL:  cap_carry = (in_amt > AMT_W) ? 1'b0 : in_data[idx_neg];
                OP_SRL:  cap_carry = (in_amt > AMT_W) ? 1'b0 : in_data[idx_dec];
                OP_SRA:  cap_carry = in_amt[SHW] ? in_data[WIDTH-1] : in_data[idx_dec];
                default: cap_carry = in_data[idx_dec];
            endcase
        end
    end

    // Pipeline advance: stage k shifts by 2^k when the low remaining-amount bit is set.
    always_comb begin
        valid_d   = valid_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        src_valid = {valid_q[SHW-2:0], fire};
        src_carry = {carry_q[SHW-2:0], cap_carry};
        src_op[0]   = in_op;
        src_rem[0]  = cap_amt;
        src_data[0] = cap_data;
        for (int k = 1; k < SHW; k++) begin
            src_op[k]   = op_q[k-1];
            src_rem[k]  = rem_q[k-1];
            src_data[k] = data_q[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            data_d[k] = data_q[k];
        end
        for (int k = 0; k < SHW - 1; k++) begin
            op_d[k]  = op_q[k];
            rem_d[k] = rem_q[k];
        end
        if (flush) begin
            valid_d = '0;
        end else if (!stall) begin
            valid_d = src_valid;
            carry_d = src_carry;
            for (int k = 0; k < SHW; k++) begin
                data_d[k] = src_rem[k][0] ? shift_by(src_op[k], src_data[k], 1 << k)
                                          : src_data[k];
            end
            for (int k = 0; k < SHW - 1; k++) begin
                op_d[k]  = src_op[k];
                rem_d[k] = src_rem[k] >> 1;
            end
            zero_d = (data_d[SHW-1] == '0);
        end
    end

    // State registers with asynchronous clear of every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            zero_q  <= 1'b0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < SHW - 1; k++) begin
                op_q[k]  <= '0;
                rem_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= data_d[k];
            end
            for (int k = 0; k < SHW - 1; k++) begin
                op_q[k]  <= op_d[k];
                rem_q[k] <= rem_d[k];
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb/tb_shift_unit_pipe.sv - randomized self-checking bench for shift_unit_pipe
module tb_shift_unit_pipe;

    localparam int W  = 32;
    localparam int SH = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  in_data;
    logic [SH:0]   in_amt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_carry;
    logic          out_zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_total = 0;
    bit sending;

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        int           acc;
        int           st;
    } exp_t;
    exp_t q[$];

    shift_unit_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] d, input int n);
        logic [W-1:0] r;
        logic         c;
        int           m;
        r = d;
        c = 1'b0;
        case (op)
            2'd0: begin
                if (n >= W) r = '0; else r = d << n;
                if (n >= 1 && n <= W) c = d[W-n];
            end
            2'd1: begin
                if (n >= W) r = '0; else r = d >> n;
                if (n >= 1 && n <= W) c = d[n-1];
            end
            2'd2: begin
                if (n >= W) r = {W{d[W-1]}}; else r = W'($signed(d) >>> n);
                if (n >= W) c = d[W-1]; else if (n >= 1) c = d[n-1];
            end
            default: begin
                m = n % W;
                if (m != 0) r = (d >> m) | (d << (W - m));
                if (n != 0) c = r[W-1];
            end
        endcase
        return {c, r};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Scoreboard and protocol checker, sampled on the falling edge.
    initial begin : monitor
        bit           head_seen = 0;
        bit           prev_stall = 0;
        bit           prev_flush = 0;
        logic [W-1:0] prev_data = '0;
        logic         prev_carry = 0;
        logic         prev_zero = 0;
        logic [W:0]   r;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                head_seen  = 0;
                prev_stall = 0;
                prev_flush = 0;
            end else begin
                if (prev_flush) begin
                    chk("flush_drop", W'(out_valid), '0);
                end else if (prev_stall) begin
                    chk("hold_valid", W'(out_valid), W'(1));
                    chk("hold_data", out_data, prev_data);
                    chk("hold_carry", W'(out_carry), W'(prev_carry));
                    chk("hold_zero", W'(out_zero), W'(prev_zero));
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_out", W'(out_valid), '0);
                    end else begin
                        if (!head_seen) begin
                            head_seen = 1;
                            chk("latency", W'(cyc - q[0].acc - (stall_total - q[0].st)), W'(SH));
                        end
                        if (out_ready) begin
                            chk("out_data", out_data, q[0].d);
                            chk("out_carry", W'(out_carry), W'(q[0].c));
                            chk("out_zero", W'(out_zero), W'(q[0].d == '0));
                            void'(q.pop_front());
                            head_seen = 0;
                        end
                    end
                end
                chk("in_ready", W'(in_ready), W'(!(out_valid && !out_ready)));
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_carry = out_carry;
                prev_zero  = out_zero;
                if (prev_stall) stall_total++;
                prev_flush = flush;
                if (flush) begin
                    q.delete();
                    head_seen = 0;
                end else if (in_valid && in_ready) begin
                    r     = model(in_op, in_data, int'(in_amt));
                    e.d   = r[W-1:0];
                    e.c   = r[W];
                    e.acc = cyc;
                    e.st  = stall_total;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [W-1:0] d, input logic [SH:0] a);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout at cycle %0d: in_ready never rose", cyc);
        end
    endtask

    task automatic send_rand();
        send(2'($urandom_range(0, 3)), $urandom, (SH+1)'($urandom_range(0, 2*W-1)));
    endtask

    task automatic directed(input logic [1:0] op, input logic [W-1:0] d, input int a,
                            input logic [W-1:0] exp_d, input logic exp_c);
        logic [W:0] r;
        r = model(op, d, a);
        chk("model_pin_data", r[W-1:0], exp_d);
        chk("model_pin_carry", W'(r[W]), W'(exp_c));
        send(op, d, (SH+1)'(a));
    endtask

    task automatic drain();
        for (int w = 0; w < 300 && q.size() != 0; w++) @(posedge clk);
        #1;
        chk("drain_empty", W'(q.size()), '0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_data   = '0;
        in_amt    = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_carry", W'(out_carry), '0);
        chk("rst_out_zero", W'(out_zero), '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rst_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;

        directed(2'd2, 32'h8000_0000, 4,  32'hF800_0000, 1'b0);
        directed(2'd2, 32'h8000_0000, 40, 32'hFFFF_FFFF, 1'b1);
        directed(2'd2, 32'h7FFF_FFFF, 40, 32'h0000_0000, 1'b0);
        directed(2'd1, 32'h8000_0001, 1,  32'h4000_0000, 1'b1);
        directed(2'd1, 32'h8000_0000, 32, 32'h0000_0000, 1'b1);
        directed(2'd0, 32'h0000_0001, 32, 32'h0000_0000, 1'b1);
        directed(2'd0, 32'h0000_0001, 33, 32'h0000_0000, 1'b0);
        for (int op = 0; op < 4; op++) begin
            directed(2'(op), 32'h9ABC_DEF1, 0, 32'h9ABC_DEF1, 1'b0);
        end
        directed(2'd3, 32'h0000_0001, 1,  32'h8000_0000, 1'b1);
        directed(2'd3, 32'h0000_0001, 36, 32'h1000_0000, 1'b0);
        directed(2'd3, 32'h8000_0000, 32, 32'h8000_0000, 1'b1);
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++) send_rand();
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 3; i++) send_rand();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 2'd1;
        in_data  = 32'hDEAD_BEEF;
        in_amt   = 6'd3;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        send(2'd0, 32'h0000_00F0, 6'd4);
        drain();

        for (int i = 0; i < 3; i++) send_rand();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", W'(out_valid), '0);
        chk("midrst_out_data", out_data, '0);
        chk("midrst_out_carry", W'(out_carry), '0);
        chk("midrst_out_zero", W'(out_zero), '0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(2'd2, 32'hF000_000F, 6'd2);
        drain();

        sending = 1;
        fork
            begin
                for (int i = 0; i < 150; i++) send_rand();
                sending = 0;
            end
            begin
                while (sending) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
